// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: control inputs, ROM address/data and the IF/ID register outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_if;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic        new_pc_en;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] inst;
  logic [31:0] inst_address;
  logic        ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  modport master (
    input  stall_if, stall_id, flush, new_pc_en, new_pc,
    input  branch_flag, branch_target, inst,
    output inst_address, ce, id_pc, id_inst, id_valid, id_adel
  );

  modport slave (
    output stall_if, stall_id, flush, new_pc_en, new_pc,
    output branch_flag, branch_target, inst,
    input  inst_address, ce, id_pc, id_inst, id_valid, id_adel
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the ROM, registers the returned word into IF/ID.
// One-cycle ROM-to-id_inst latency; stall_if freezes the PC, stall_id freezes IF/ID.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] FLUSH_PC = 32'h0000_0040
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  logic [31:0] pc;
  logic        ce;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ce          <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      id_pc       <= '0;
      id_inst     <= '0;
      id_valid    <= 1'b0;
      id_adel     <= 1'b0;
    end else begin
      ce <= 1'b1;

      if (ce) begin
        if (bus.flush) begin
          pc         <= bus.new_pc_en ? bus.new_pc : FLUSH_PC;
          pend_valid <= 1'b0;
        end else if (bus.stall_if) begin
          // A branch resolved while IF is frozen is remembered and taken on release.
          if (bus.branch_flag) begin
            pend_valid  <= 1'b1;
            pend_target <= bus.branch_target;
          end
        end else if (bus.branch_flag) begin
          pc         <= bus.branch_target;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          pc         <= pend_target;
          pend_valid <= 1'b0;
        end else begin
          pc <= pc + 32'd4;
        end
      end

      if (bus.flush) begin
        id_pc    <= '0;
        id_inst  <= '0;
        id_valid <= 1'b0;
        id_adel  <= 1'b0;
      end else if (!bus.stall_id) begin
        if (bus.stall_if || !ce) begin
          id_pc    <= '0;
          id_inst  <= '0;
          id_valid <= 1'b0;
          id_adel  <= 1'b0;
        end else begin
          id_pc    <= pc;
          id_inst  <= misaligned ? 32'h0 : bus.inst;
          id_valid <= 1'b1;
          id_adel  <= misaligned;
        end
      end
    end
  end

  assign bus.inst_address = pc;
  assign bus.ce           = ce;
  assign bus.id_pc        = id_pc;
  assign bus.id_inst      = id_inst;
  assign bus.id_valid     = id_valid;
  assign bus.id_adel      = id_adel;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle vector table plus hand sequences, expectations via a queue.
// The ROM returns address + 32'h1000_0000 so every fetched word is traceable to its PC.
module tb_inst_fetch;

  logic clk;
  logic rst;
  inst_fetch_if bus();

  inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] ROM_OFS = 32'h1000_0000;
  assign bus.inst = bus.inst_address + ROM_OFS;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sif;
    logic        sid;
    logic        fl;
    logic        npe;
    logic [31:0] npc;
    logic        br;
    logic [31:0] bt;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_idpc;
    logic        e_valid;
    logic        e_adel;
  } vec_t;

  typedef struct {
    int          tag;
    logic [31:0] addr;
    logic        ce;
    logic [31:0] idpc;
    logic [31:0] idinst;
    logic        valid;
    logic        adel;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t v(logic r, logic sif, logic sid, logic fl, logic npe,
                             logic [31:0] npc, logic br, logic [31:0] bt,
                             logic [31:0] addr, logic ce, logic [31:0] idpc,
                             logic valid, logic adel);
    vec_t x;
    x.rst = r; x.sif = sif; x.sid = sid; x.fl = fl; x.npe = npe; x.npc = npc;
    x.br = br; x.bt = bt; x.e_addr = addr; x.e_ce = ce; x.e_idpc = idpc;
    x.e_valid = valid; x.e_adel = adel;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(int tag, vec_t x);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst               = x.rst;
    bus.stall_if      = x.sif;
    bus.stall_id      = x.sid;
    bus.flush         = x.fl;
    bus.new_pc_en     = x.npe;
    bus.new_pc        = x.npc;
    bus.branch_flag   = x.br;
    bus.branch_target = x.bt;
    e.tag    = tag;
    e.addr   = x.e_addr;
    e.ce     = x.e_ce;
    e.idpc   = x.e_idpc;
    e.valid  = x.e_valid;
    e.adel   = x.e_adel;
    e.idinst = (x.e_valid && !x.e_adel) ? x.e_idpc + ROM_OFS : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check($sformatf("v%0d inst_address", got.tag), bus.inst_address, got.addr);
    check($sformatf("v%0d ce", got.tag), {31'b0, bus.ce}, {31'b0, got.ce});
    check($sformatf("v%0d id_pc", got.tag), bus.id_pc, got.idpc);
    check($sformatf("v%0d id_inst", got.tag), bus.id_inst, got.idinst);
    check($sformatf("v%0d id_valid", got.tag), {31'b0, bus.id_valid}, {31'b0, got.valid});
    check($sformatf("v%0d id_adel", got.tag), {31'b0, bus.id_adel}, {31'b0, got.adel});
  endtask

  initial begin
    rst = 1'b1;
    bus.stall_if = 0; bus.stall_id = 0; bus.flush = 0; bus.new_pc_en = 0;
    bus.new_pc = '0; bus.branch_flag = 0; bus.branch_target = '0;

    //           rst sif sid fl npe npc        br bt            addr          ce idpc          vld adel
    // reset release and sequential fetch
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h0,        1, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h4,        1, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h8,        1, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'hC,        1, 32'h8,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h10,       1, 32'hC,        1, 0));
    // branch with delay slot
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     1, 32'h100,     32'h100,      1, 32'h10,       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h104,      1, 32'h100,      1, 0));
    // three-cycle stall with a branch in the middle
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,     0, 32'h0,       32'h104,      1, 32'h100,      1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,     1, 32'h200,     32'h104,      1, 32'h100,      1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,     0, 32'h0,       32'h104,      1, 32'h100,      1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h200,      1, 32'h104,      1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h204,      1, 32'h200,      1, 0));
    // flush to FLUSH_PC drops a pending branch; flush to new_pc
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,     1, 32'h300,     32'h204,      1, 32'h200,      1, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 32'h999,   0, 32'h0,       32'h40,       1, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h44,       1, 32'h40,       1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h80,    0, 32'h0,       32'h80,       1, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h84,       1, 32'h80,       1, 0));
    // misaligned target, then PC wrap at the top of the address space
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     1, 32'h102,     32'h102,      1, 32'h84,       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h106,      1, 32'h102,      1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h106,   1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h0,        1, 32'hFFFF_FFFC, 1, 0));
    // stall_if alone inserts a bubble
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,     0, 32'h0,       32'h0,        1, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h4,        1, 32'h0,        1, 0));
    // reset during a stall with a pending branch
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,     1, 32'h500,     32'h4,        1, 32'h0,        1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 32'h0,     0, 32'h0,       32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h0,        1, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 32'h0,       32'h4,        1, 32'h0,        1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // A second branch in the same stall replaces the first pending target.
    apply(100, v(0, 1, 1, 0, 0, 32'h0, 1, 32'h600, 32'h4,   1, 32'h0,   1, 0));
    apply(101, v(0, 1, 1, 0, 0, 32'h0, 1, 32'h700, 32'h4,   1, 32'h0,   1, 0));
    apply(102, v(0, 0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h700, 1, 32'h4,   1, 0));
    apply(103, v(0, 0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h704, 1, 32'h700, 1, 0));

    // A branch coinciding with the release edge wins over the pending target.
    apply(110, v(0, 1, 1, 0, 0, 32'h0, 1, 32'h800, 32'h704, 1, 32'h700, 1, 0));
    apply(111, v(0, 0, 0, 0, 0, 32'h0, 1, 32'h900, 32'h900, 1, 32'h704, 1, 0));
    apply(112, v(0, 0, 0, 0, 0, 32'h0, 0, 32'h0,   32'h904, 1, 32'h900, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
